mdu_ctrl: RTL and testbench
===========================

// Module: mdu_ctrl
// PURPOSE
//  EX-stage multiply control, directly upstream of the 32x32 multiplier (mul_alu).
//  Decodes MULT/MULTU/MUL/MTHI/MTLO/MFHI/MFLO, issues start/operands/signedness to the
//  multiplier and stalls EX until its result returns.
//  Owns the architectural HI/LO registers and returns the MUL/MFHI/MFLO result to the GPR path.
// PARAMETERS
//  TIMEOUT   16            max BUSY cycles without mul_done before abort (>=2)
//  HI_RST    32'h0000_0000 reset value of HI
//  LO_RST    32'h0000_0000 reset value of LO
// PORTS
//  cpu_clk     in   1   clock, all state on rising edge
//  cpu_rstn    in   1   asynchronous, active-low reset
//  ex_valid    in   1   EX holds a valid instruction
//  ex_op       in   3   0 NOP,1 MULT,2 MULTU,3 MUL,4 MTHI,5 MTLO,6 MFHI,7 MFLO
//  ex_rs       in   32  rs operand (forwarded)
//  ex_rt       in   32  rt operand (forwarded)
//  flush       in   1   kill EX instruction (exception/redirect)
//  ex_stall    out  1   hold EX and earlier stages
//  mdu_rdata   out  32  GPR result: MUL low word, HI or LO
//  mdu_rvalid  out  1   mdu_rdata valid this cycle
//  hi_o, lo_o  out  32  current HI / LO
//  mdu_err     out  1   sticky: multiplier timeout seen
//  mul_start   out  1   to multiplier: sample operands this edge
//  mul_reg1    out  32  = ex_rs
//  mul_reg2    out  32  = ex_rt
//  mul_signed  out  1   1 for MULT/MUL, 0 for MULTU
//  mul_done    in   1   from multiplier: mul_result valid
//  mul_result  in   64  from multiplier: {hi,lo} product
// BEHAVIOUR
//  Reset: state IDLE, HI=HI_RST, LO=LO_RST, ex_stall=0, mdu_rvalid=0, mdu_err=0,
//   mul_start=0, result reg=0, timeout counter=0.
//  FSM: IDLE, BUSY, DONE. mul_op = ex_valid & ~flush & ex_op in {1,2,3}.
//  IDLE: mul_op -> mul_start=1 (combinational, exactly one cycle), latch op, ex_stall=1,
//   go BUSY. Else stay; ex_stall=0.
//  BUSY: ex_stall=1, mul_start=0, counter++.
//   flush -> IDLE, mul_done ignored, HI/LO untouched.
//   mul_done (no flush) -> MULT/MULTU: {HI,LO}<=mul_result; MUL: result reg<=mul_result[31:0]
//   (HI/LO untouched); go DONE.
//   counter reaches TIMEOUT-1 without done -> mdu_err<=1, IDLE, no write.
//  DONE: ex_stall=0; MUL -> mdu_rvalid=1, mdu_rdata=result reg; EX advances this edge; go IDLE
//   unconditionally (no restart on same instruction).
//  Nominal latency with 1-cycle multiplier: start cycle T, done T+1, DONE T+2; EX stalled
//   2 cycles; HI/LO visible from T+2.
//  MTHI/MTLO: in IDLE, ex_valid & ~flush: HI (LO) <= ex_rs at edge; no stall.
//  MFHI/MFLO: in IDLE, ex_valid & ~flush: mdu_rvalid=1, mdu_rdata=HI (LO) combinational
//   from registers; no stall.
//  flush in IDLE suppresses start, writes and rvalid. Any op other than 1..7 -> no action.
//  mdu_rdata=0 when mdu_rvalid=0. mdu_err cleared only by reset.
//  Reset mid-operation: async return to reset values; an in-flight product is discarded.
// TESTING
//  MULT rs=FFFFFFFD(-3) rt=5 -> mul_signed=1, stall 2 cycles, HI=FFFFFFFF LO=FFFFFFF1
//  MULTU rs=FFFFFFFF rt=2 -> mul_signed=0, HI=00000001 LO=FFFFFFFE
//  MUL 7*6 with HI/LO=AAAA/5555 -> DONE cycle rvalid=1 rdata=0000002A, HI/LO unchanged
//  MULT then flush in BUSY cycle (mul_done=1) -> IDLE, HI/LO unchanged, no rvalid
//  MTLO 12345678 then MFLO next cycle -> rvalid=1 rdata=12345678, ex_stall=0 throughout
//  mul_done tied 0, MULT issued -> after TIMEOUT BUSY cycles mdu_err=1, IDLE, stall drops

Source files
------------

// File: rtl/mdu_ctrl.sv
// EX-stage multiply/divide-unit control: issues products to the external multiplier,
// stalls EX while it runs, and owns the architectural HI/LO registers.
//
// state | meaning
// IDLE  | accepting instructions; MTHI/MTLO/MFHI/MFLO complete here in one cycle
// BUSY  | product in flight, EX stalled, timeout counter running
// DONE  | product written back; EX released for one cycle
module mdu_ctrl #(
  parameter int          TIMEOUT = 16,
  parameter logic [31:0] HI_RST  = 32'h0000_0000,
  parameter logic [31:0] LO_RST  = 32'h0000_0000
) (
  input  logic        cpu_clk,
  input  logic        cpu_rstn,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs,
  input  logic [31:0] ex_rt,
  input  logic        flush,
  output logic        ex_stall,
  output logic [31:0] mdu_rdata,
  output logic        mdu_rvalid,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o,
  output logic        mdu_err,
  output logic        mul_start,
  output logic [31:0] mul_reg1,
  output logic [31:0] mul_reg2,
  output logic        mul_signed,
  input  logic        mul_done,
  input  logic [63:0] mul_result
);

  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_MUL   = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;
  localparam logic [2:0] OP_MFHI  = 3'd6;
  localparam logic [2:0] OP_MFLO  = 3'd7;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d, res_q, res_d;
  logic            is_mul_q, is_mul_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            req, mul_op;

  assign req    = ex_valid & ~flush;
  assign mul_op = req & ((ex_op == OP_MULT) | (ex_op == OP_MULTU) | (ex_op == OP_MUL));

  // EX holds the instruction while stalled, so operands and signedness stay stable
  assign mul_reg1   = ex_rs;
  assign mul_reg2   = ex_rt;
  assign mul_signed = (ex_op == OP_MULT) | (ex_op == OP_MUL);

  assign hi_o    = hi_q;
  assign lo_o    = lo_q;
  assign mdu_err = err_q;

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q  <= S_IDLE;
      hi_q     <= HI_RST;
      lo_q     <= LO_RST;
      res_q    <= 32'h0;
      is_mul_q <= 1'b0;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      is_mul_q <= is_mul_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    res_d      = res_q;
    is_mul_d   = is_mul_q;
    err_d      = err_q;
    cnt_d      = cnt_q;
    ex_stall   = 1'b0;
    mul_start  = 1'b0;
    mdu_rvalid = 1'b0;
    mdu_rdata  = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (mul_op) begin
          mul_start = 1'b1;
          ex_stall  = 1'b1;
          is_mul_d  = (ex_op == OP_MUL);
          cnt_d     = '0;
          state_d   = S_BUSY;
        end else if (req) begin
          case (ex_op)
            OP_MTHI: hi_d = ex_rs;
            OP_MTLO: lo_d = ex_rs;
            OP_MFHI: begin
              mdu_rvalid = 1'b1;
              mdu_rdata  = hi_q;
            end
            OP_MFLO: begin
              mdu_rvalid = 1'b1;
              mdu_rdata  = lo_q;
            end
            default: ;
          endcase
        end
      end
      S_BUSY: begin
        ex_stall = 1'b1;
        cnt_d    = cnt_q + CW'(1);
        if (flush) begin
          state_d = S_IDLE;
        end else if (mul_done) begin
          if (is_mul_q) res_d = mul_result[31:0];
          else          {hi_d, lo_d} = mul_result;
          state_d = S_DONE;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        // the finished instruction leaves EX on this edge, so never re-issue it
        state_d = S_IDLE;
        if (is_mul_q) begin
          mdu_rvalid = 1'b1;
          mdu_rdata  = res_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed cases plus random instruction streams checked
// against an architectural HI/LO/err model and an emulated variable-latency multiplier.
module tb_mdu_ctrl;
  localparam int TO = 16;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs, ex_rt;
  logic        flush;
  logic        ex_stall;
  logic [31:0] mdu_rdata;
  logic        mdu_rvalid;
  logic [31:0] hi_o, lo_o;
  logic        mdu_err;
  logic        mul_start;
  logic [31:0] mul_reg1, mul_reg2;
  logic        mul_signed;
  logic        mul_done;
  logic [63:0] mul_result;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_hi, m_lo;
  logic        m_err;

  always #5 cpu_clk = ~cpu_clk;

  mdu_ctrl #(.TIMEOUT(TO), .HI_RST(32'h0), .LO_RST(32'h0)) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .flush(flush), .ex_stall(ex_stall),
    .mdu_rdata(mdu_rdata), .mdu_rvalid(mdu_rvalid), .hi_o(hi_o), .lo_o(lo_o),
    .mdu_err(mdu_err), .mul_start(mul_start), .mul_reg1(mul_reg1), .mul_reg2(mul_reg2),
    .mul_signed(mul_signed), .mul_done(mul_done), .mul_result(mul_result)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b, input bit s);
    logic [63:0] x, y;
    x = s ? {{32{a[31]}}, a} : {32'h0, a};
    y = s ? {{32{b[31]}}, b} : {32'h0, b};
    return x * y;
  endfunction

  task automatic check_arch();
    chk("hi", hi_o, m_hi);
    chk("lo", lo_o, m_lo);
    chk("err", mdu_err, m_err);
  endtask

  // one IDLE-cycle instruction that must not start the multiplier
  task automatic do_simple(input logic [2:0] op, input logic [31:0] rs, input bit v, input bit fl);
    bit acc;
    logic [31:0] exp_d;
    @(negedge cpu_clk);
    ex_valid = v; ex_op = op; ex_rs = rs; ex_rt = $urandom; flush = fl;
    mul_done = 1'b0; mul_result = {$urandom, $urandom};
    #1;
    acc = v && !fl;
    check_arch();
    chk("s_stall", ex_stall, 0);
    chk("s_start", mul_start, 0);
    exp_d = (acc && op == 3'd6) ? m_hi : (acc && op == 3'd7) ? m_lo : 32'h0;
    chk("s_rvalid", mdu_rvalid, acc && (op == 3'd6 || op == 3'd7));
    chk("s_rdata", mdu_rdata, exp_d);
    if (acc && op == 3'd4) m_hi = rs;
    if (acc && op == 3'd5) m_lo = rs;
  endtask

  // lat = BUSY cycle (1-based) carrying mul_done, 0 = never; fl_at = BUSY cycle with flush, 0 = none
  task automatic do_mul(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input int lat, input int fl_at);
    logic [63:0] p;
    bit sgn, done, ended;
    sgn = (op != 3'd2);
    p = prod(rs, rt, sgn);
    @(negedge cpu_clk);
    ex_valid = 1'b1; ex_op = op; ex_rs = rs; ex_rt = rt; flush = 1'b0;
    mul_done = 1'b0; mul_result = {$urandom, $urandom};
    #1;
    check_arch();
    chk("m_start", mul_start, 1);
    chk("m_stall", ex_stall, 1);
    chk("m_signed", mul_signed, sgn);
    chk("m_reg1", mul_reg1, rs);
    chk("m_reg2", mul_reg2, rt);
    chk("m_rvalid", mdu_rvalid, 0);
    done = 0; ended = 0;
    for (int c = 1; c <= TO && !done && !ended; c++) begin
      @(negedge cpu_clk);
      flush = (c == fl_at);
      mul_done = (c == lat);
      mul_result = (c == lat) ? p : {$urandom, $urandom};
      #1;
      chk("b_stall", ex_stall, 1);
      chk("b_start", mul_start, 0);
      chk("b_rvalid", mdu_rvalid, 0);
      if (c == fl_at) ended = 1;
      else if (c == lat) done = 1;
      else if (c == TO) begin
        m_err = 1'b1;
        ended = 1;
      end
    end
    if (done) begin
      if (op != 3'd3) {m_hi, m_lo} = p;
      @(negedge cpu_clk);
      flush = 1'b0; mul_done = 1'b0; mul_result = {$urandom, $urandom};
      #1;
      check_arch();
      chk("d_stall", ex_stall, 0);
      chk("d_start", mul_start, 0);
      chk("d_rvalid", mdu_rvalid, op == 3'd3);
      chk("d_rdata", mdu_rdata, (op == 3'd3) ? {32'h0, p[31:0]} : 64'h0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, fl_at;
    bit v, fl;
    logic [2:0] op;
    cpu_rstn = 1'b0;
    ex_valid = 1'b0; ex_op = 3'd0; ex_rs = 32'h0; ex_rt = 32'h0; flush = 1'b0;
    mul_done = 1'b0; mul_result = 64'h0;
    m_hi = 32'h0; m_lo = 32'h0; m_err = 1'b0;
    #12;
    check_arch();
    chk("rst_stall", ex_stall, 0);
    chk("rst_rvalid", mdu_rvalid, 0);
    chk("rst_rdata", mdu_rdata, 0);
    chk("rst_start", mul_start, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;

    do_mul(3'd1, 32'hFFFF_FFFD, 32'd5, 1, 0);
    do_simple(3'd0, 32'h0, 1, 0);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFF1);

    do_mul(3'd2, 32'hFFFF_FFFF, 32'd2, 1, 0);
    do_simple(3'd0, 32'h0, 1, 0);
    chk("multu_hi", hi_o, 32'h0000_0001);
    chk("multu_lo", lo_o, 32'hFFFF_FFFE);

    do_simple(3'd4, 32'h0000_AAAA, 1, 0);
    do_simple(3'd5, 32'h0000_5555, 1, 0);
    do_mul(3'd3, 32'd7, 32'd6, 1, 0);
    do_simple(3'd0, 32'h0, 1, 0);
    chk("mul_hi", hi_o, 32'h0000_AAAA);
    chk("mul_lo", lo_o, 32'h0000_5555);

    do_mul(3'd1, 32'h1234_5678, 32'h0000_0100, 1, 1);
    do_simple(3'd0, 32'h0, 1, 0);
    chk("flush_hi", hi_o, 32'h0000_AAAA);

    do_simple(3'd5, 32'h1234_5678, 1, 0);
    do_simple(3'd7, 32'h0, 1, 0);
    chk("mflo_rdata", mdu_rdata, 32'h1234_5678);

    do_simple(3'd1, 32'h5, 1, 1);
    do_simple(3'd6, 32'h0, 1, 1);

    do_mul(3'd1, 32'h3, 32'h4, 0, 0);
    do_simple(3'd0, 32'h0, 1, 0);
    chk("to_err", mdu_err, 1);
    do_mul(3'd2, 32'h3, 32'h4, 2, 0);

    @(negedge cpu_clk);
    ex_valid = 1'b1; ex_op = 3'd1; ex_rs = 32'h7; ex_rt = 32'h9; flush = 1'b0; mul_done = 1'b0;
    @(negedge cpu_clk);
    #1;
    cpu_rstn = 1'b0;
    ex_valid = 1'b0;
    #1;
    m_hi = 32'h0; m_lo = 32'h0; m_err = 1'b0;
    check_arch();
    chk("arst_stall", ex_stall, 0);
    chk("arst_start", mul_start, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    do_simple(3'd0, 32'h0, 1, 0);

    for (int i = 0; i < 400; i++) begin
      op = 3'($urandom_range(0, 7));
      v  = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 7) == 0);
      if (v && !fl && op >= 3'd1 && op <= 3'd3) begin
        lat   = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 4));
        fl_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, (lat == 0) ? 3 : lat)) : 0;
        do_mul(op, $urandom, $urandom, lat, fl_at);
      end else begin
        do_simple(op, $urandom, v, fl);
      end
    end
    do_simple(3'd0, 32'h0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
